// File: rtl/core_pkg.sv
// Shared core definitions used by the fetch queue and its neighbours:
// the canonical NOP, the opcode field position and the fetch entry layout.
package core_pkg;

  localparam int CORE_XLEN = 32;

  // ADDI x0, x0, 0 -- what decode sees when the fetch queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Position of the 5-bit major opcode inside a 32-bit instruction
  localparam int OPCODE_LSB = 2;
  localparam int OPCODE_MSB = 6;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small circular instruction buffer between fetch and decode.
// Accepts {pc, instr} over valid/ready, presents the head with its opcode
// pre-sliced, and clears itself on a redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty an incoming
// entry is forwarded combinationally to the outputs (zero latency).
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [4:0]                 out_opcode,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage is deliberately left unreset; only the pointers and count matter
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic head_valid;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  // Handshake, head selection and the write/read enables derived from them
  always_comb begin
    head_valid = (count != '0);
    in_ready   = (count != FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (count == '0) && in_valid && !flush;
`else
    bypass = 1'b0;
`endif

    out_valid = head_valid || bypass;

    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (head_valid) begin
      out_pc    = mem_pc[rd_ptr];
      out_instr = mem_instr[rd_ptr];
    end else begin
      out_pc    = '0;
      out_instr = XLEN'(NOP_INSTR);
    end

    out_opcode  = out_instr[OPCODE_MSB:OPCODE_LSB];
    out_illegal = out_valid && (out_instr[1:0] != 2'b11);

    push = in_valid && in_ready;
    pop  = out_valid && out_ready;

    // A bypassed entry that decode takes immediately never touches storage,
    // and a bypass pop consumes nothing from storage either
    wr_en = push && !(bypass && out_ready);
    rd_en = pop && !bypass;
  end

  // Entry storage write port
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=2, XLEN=32).
// Expected values are hand-derived; bypass-dependent expectations follow
// FETCH_QUEUE_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [XLEN-1:0]        in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        out_instr;
  logic [4:0]             out_opcode;
  logic                   out_illegal;
  logic [$clog2(DEPTH):0] count;

  int assertCount = 0;
  int failCount   = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_illegal (out_illegal),
    .count       (count)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance past the next rising edge, then return inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  // Main directed sequence
  initial begin
    logic [31:0] expHead;

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_out_instr_nop", 64'(out_instr), 64'h13);
    checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
    checkOutput("rst_opcode", 64'(out_opcode), 64'h04);
    checkOutput("rst_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single push becomes visible next cycle
    applyStimulus(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
    tick();
    checkOutput("push1_out_valid", 64'(out_valid), 64'd1);
    checkOutput("push1_opcode", 64'(out_opcode), 64'h04);
    checkOutput("push1_out_pc", 64'(out_pc), 64'h100);
    checkOutput("push1_count", 64'(count), 64'd1);

    // Drain it, then fill with decode stalled
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h104, 32'h0000_0033, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h108, 32'h0000_2003, 1'b0, 1'b0);
    tick();
    checkOutput("fill_count", 64'(count), 64'd2);
    checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h10C, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    checkOutput("full_push_count", 64'(count), 64'd2);
    checkOutput("full_push_head", 64'(out_pc), 64'h104);
    checkOutput("full_head_instr", 64'(out_instr), 64'h33);

    // Full with a pop in the same cycle: pop taken, push refused
    applyStimulus(1'b1, 32'h10C, 32'h0000_0013, 1'b1, 1'b0);
    tick();
    checkOutput("full_pop_count", 64'(count), 64'd1);
    checkOutput("full_pop_head", 64'(out_pc), 64'h108);

    // Simultaneous push/pop at count 1 across several pointer wraps
    expHead = 32'h108;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'h0000_0013, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("stream_head_%0d", i), 64'(out_pc), 64'(expHead));
      tick();
      expHead = 32'h300 + 32'(4 * i);
      checkOutput($sformatf("stream_count_%0d", i), 64'(count), 64'd1);
    end
    checkOutput("stream_last_head", 64'(out_pc), 64'h314);

    // Refill to two entries, then flush with a push pending
    applyStimulus(1'b1, 32'h318, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    checkOutput("preflush_count", 64'(count), 64'd2);
    applyStimulus(1'b1, 32'h31C, 32'h0000_0013, 1'b1, 1'b1);
    #1;
    checkOutput("flush_cycle_in_ready", 64'(in_ready), 64'd0);
    tick();
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_out_instr", 64'(out_instr), 64'h13);

    // Flush while empty with in_valid: nothing presented, nothing kept
    applyStimulus(1'b1, 32'h320, 32'h0000_0013, 1'b0, 1'b1);
    #1;
    checkOutput("flush_empty_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_empty_in_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("flush_empty_count", 64'(count), 64'd0);

    // Illegal (non-32-bit) encoding at the head
    applyStimulus(1'b1, 32'h400, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    checkOutput("illegal_flag", 64'(out_illegal), 64'd1);
    checkOutput("illegal_opcode", 64'(out_opcode), 64'h00);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("empty_illegal", 64'(out_illegal), 64'd0);

    // Async reset mid-cycle at count 2
    applyStimulus(1'b1, 32'h404, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h408, 32'h0000_0033, 1'b0, 1'b0);
    tick();
    checkOutput("prereset_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'h200, 32'h0050_0093, 1'b0, 1'b0);
    #1;
    checkOutput("post_rst_same_cycle_valid", 64'(out_valid), 64'(BYPASS));
    tick();
    checkOutput("post_rst_out_pc", 64'(out_pc), 64'h200);
    checkOutput("post_rst_count", 64'(count), 64'd1);

    // Empty queue with push and pop offered together
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h500, 32'h0000_0013, 1'b1, 1'b0);
    #1;
    checkOutput("empty_pushpop_valid", 64'(out_valid), 64'(BYPASS));
    tick();
    checkOutput("empty_pushpop_count", 64'(count), BYPASS ? 64'd0 : 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
